// File: rtl/out_port_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | out_port_pkg : constants shared by out_port and the downstream port    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package out_port_pkg;

  localparam int NUM_PORTS = 3;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 2;

  localparam logic [ADDR_W-1:0] NO_PORT = 2'b11;

  // data_out layout: {valid, payload}
  localparam int PAYLOAD_LSB = 0;

  function automatic int dout_valid_pos(input int data_w);
    return data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | out_port_buf : two-entry in-order buffer with toggling pointers        |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module out_port_buf #(
  parameter int DATA_W = out_port_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              not_full
);
  import out_port_pkg::*;

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        vld_q, vld_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic              do_push, do_pop;

  // push targets an empty slot and pop a full one, so they never collide
  always_comb begin
    do_push = push & ~vld_q[wptr_q];
    do_pop  = pop & vld_q[rptr_q];
    mem_d   = mem_q;
    vld_d   = vld_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = ~wptr_q;
    end
    if (do_pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = ~rptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 2'b00;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // payload storage carries no reset; the valid bits qualify it
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout       = mem_q[rptr_q];
  assign dout_valid = vld_q[rptr_q];
  assign not_full   = ~vld_q[wptr_q];

endmodule
`default_nettype wire

// File: rtl/out_port.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | out_port : per-port core write buffers muxed onto one interconnect link|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module out_port #(
  parameter int NUM_PORTS = out_port_pkg::NUM_PORTS,
  parameter int DATA_W    = out_port_pkg::DATA_W
) (
  input  logic                           gclock,
  input  logic                           reset,
  input  logic [out_port_pkg::ADDR_W-1:0] c_addr,
  input  logic                           c_write,
  input  logic [DATA_W-1:0]              c_data,
  output logic [NUM_PORTS-1:0]           c_space,
  output logic                           c_drop,
  input  logic [out_port_pkg::ADDR_W-1:0] o_addr,
  input  logic                           valid_back,
  output logic [DATA_W:0]                data_out
);
  import out_port_pkg::*;

  localparam int VLD_POS = dout_valid_pos(DATA_W);

  logic [ADDR_W-1:0] o_addr_q, o_addr_d;
  logic              c_drop_q, c_drop_d;

  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] not_full;
  logic [NUM_PORTS-1:0] buf_valid;
  logic [DATA_W-1:0]    buf_dout [NUM_PORTS];

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign push[p] = c_write & (c_addr == ADDR_W'(p));
      // the buffer itself refuses to pop when its head is empty
      assign pop[p]  = (o_addr_q == ADDR_W'(p)) & ~valid_back;

      out_port_buf #(
        .DATA_W (DATA_W)
      ) u_buf (
        .clk        (gclock),
        .rst_n      (reset),
        .push       (push[p]),
        .pop        (pop[p]),
        .din        (c_data),
        .dout       (buf_dout[p]),
        .dout_valid (buf_valid[p]),
        .not_full   (not_full[p])
      );
    end
  endgenerate

  // fullness is judged before the edge, so a same-edge send never rescues a write
  always_comb begin
    c_drop_d = 1'b0;
    o_addr_d = o_addr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p] && !not_full[p]) c_drop_d = 1'b1;
    end
  end

  always_ff @(posedge gclock or negedge reset) begin
    if (!reset) begin
      o_addr_q <= NO_PORT;
      c_drop_q <= 1'b0;
    end else begin
      o_addr_q <= o_addr_d;
      c_drop_q <= c_drop_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (o_addr_q == ADDR_W'(p)) begin
        data_out[VLD_POS]                   = buf_valid[p];
        data_out[VLD_POS-1:PAYLOAD_LSB]     = buf_dout[p];
      end
    end
  end

  assign c_space = not_full;
  assign c_drop  = c_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_out_port.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_out_port : directed self-checking bench for out_port                |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_out_port;

  logic        gclock;
  logic        reset;
  logic [1:0]  c_addr;
  logic        c_write;
  logic [31:0] c_data;
  logic [2:0]  c_space;
  logic        c_drop;
  logic [1:0]  o_addr;
  logic        valid_back;
  logic [32:0] data_out;

  int tests = 0;
  int fails = 0;

  out_port #(
    .NUM_PORTS (3),
    .DATA_W    (32)
  ) dut (
    .gclock     (gclock),
    .reset      (reset),
    .c_addr     (c_addr),
    .c_write    (c_write),
    .c_data     (c_data),
    .c_space    (c_space),
    .c_drop     (c_drop),
    .o_addr     (o_addr),
    .valid_back (valid_back),
    .data_out   (data_out)
  );

  initial gclock = 1'b0;
  always #5 gclock = ~gclock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    c_addr  = a;
    c_data  = d;
    c_write = 1'b1;
    tick();
    c_write = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    c_addr     = 2'b11;
    c_write    = 1'b0;
    c_data     = '0;
    o_addr     = 2'b11;
    valid_back = 1'b0;
    #2;
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_c_space",  64'(c_space),  64'h7);
    check("rst_c_drop",   64'(c_drop),   64'h0);
    #10;
    reset = 1'b1;
    tick();

    // single word through port 1
    o_addr = 2'd1;
    wr(2'd1, 32'hA5A5_0001);
    check("p1_word", 64'(data_out), 64'h1_A5A5_0001);
    check("p1_space_after_wr", 64'(c_space[1]), 64'h1);
    tick();
    check("p1_consumed_vld", 64'(data_out[32]), 64'h0);
    check("p1_space_after_pop", 64'(c_space), 64'h7);
    o_addr = 2'd3;
    tick();
    check("noport_zero", 64'(data_out), 64'h0);

    // overflow port 0
    wr(2'd0, 32'h1);
    check("p0_space_1", 64'(c_space[0]), 64'h1);
    wr(2'd0, 32'h2);
    check("p0_space_full", 64'(c_space[0]), 64'h0);
    check("p0_no_drop_yet", 64'(c_drop), 64'h0);
    wr(2'd0, 32'h3);
    check("p0_drop_pulse", 64'(c_drop), 64'h1);
    o_addr = 2'd0;
    tick();
    check("p0_drop_cleared", 64'(c_drop), 64'h0);
    check("p0_first", 64'(data_out), 64'h1_0000_0001);
    tick();
    check("p0_second", 64'(data_out), 64'h1_0000_0002);
    check("p0_space_after_pop", 64'(c_space[0]), 64'h1);
    tick();
    check("p0_empty", 64'(data_out[32]), 64'h0);
    tick();
    check("p0_no_third", 64'(data_out[32]), 64'h0);
    o_addr = 2'd3;
    tick();

    // backpressure on port 2
    valid_back = 1'b1;
    o_addr     = 2'd2;
    wr(2'd2, 32'h10);
    check("p2_word", 64'(data_out), 64'h1_0000_0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p2_held", 64'(data_out), 64'h1_0000_0010);
    end
    valid_back = 1'b0;
    tick();
    check("p2_popped", 64'(data_out[32]), 64'h0);
    tick();
    check("p2_no_dup", 64'(data_out[32]), 64'h0);
    o_addr = 2'd3;
    tick();

    // write dropped while send frees an entry on the same edge
    wr(2'd1, 32'h7);
    wr(2'd1, 32'h8);
    check("p1_full", 64'(c_space[1]), 64'h0);
    valid_back = 1'b1;
    o_addr     = 2'd1;
    tick();
    check("p1_head7", 64'(data_out), 64'h1_0000_0007);
    valid_back = 1'b0;
    wr(2'd1, 32'h9);
    check("same_edge_drop", 64'(c_drop), 64'h1);
    check("same_edge_next", 64'(data_out), 64'h1_0000_0008);
    check("same_edge_space", 64'(c_space[1]), 64'h1);
    tick();
    check("after_8_empty", 64'(data_out[32]), 64'h0);
    check("after_8_drop_low", 64'(c_drop), 64'h0);
    tick();
    check("nine_never_sent", 64'(data_out[32]), 64'h0);
    o_addr = 2'd3;
    tick();

    // interleaved sends across ports 0 and 1
    wr(2'd0, 32'hA0);
    wr(2'd0, 32'hA1);
    wr(2'd1, 32'hB0);
    wr(2'd1, 32'hB1);
    o_addr = 2'd0; tick();
    check("il_a0", 64'(data_out), 64'h1_0000_00A0);
    o_addr = 2'd1; tick();
    check("il_b0", 64'(data_out), 64'h1_0000_00B0);
    o_addr = 2'd0; tick();
    check("il_a1", 64'(data_out), 64'h1_0000_00A1);
    o_addr = 2'd1; tick();
    check("il_b1", 64'(data_out), 64'h1_0000_00B1);
    o_addr = 2'd3; tick();
    check("il_noport", 64'(data_out), 64'h0);
    o_addr = 2'd0; tick();
    check("il_p0_empty", 64'(data_out[32]), 64'h0);
    o_addr = 2'd1; tick();
    check("il_p1_empty", 64'(data_out[32]), 64'h0);
    check("il_space", 64'(c_space), 64'h7);
    o_addr = 2'd3; tick();

    // reset with every port full
    wr(2'd0, 32'hC0);
    wr(2'd0, 32'hC1);
    wr(2'd1, 32'hD0);
    wr(2'd1, 32'hD1);
    wr(2'd2, 32'hE0);
    wr(2'd2, 32'hE1);
    check("all_full", 64'(c_space), 64'h0);
    valid_back = 1'b1;
    o_addr     = 2'd0;
    tick();
    check("pre_rst_head", 64'(data_out), 64'h1_0000_00C0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_data_out", 64'(data_out), 64'h0);
    check("mid_rst_space", 64'(c_space), 64'h7);
    #2;
    reset = 1'b1;
    check("post_rst_space", 64'(c_space), 64'h7);
    valid_back = 1'b0;
    wr(2'd0, 32'h55);
    check("post_rst_first", 64'(data_out), 64'h1_0000_0055);
    tick();
    check("post_rst_popped", 64'(data_out[32]), 64'h0);
    check("post_rst_space_final", 64'(c_space), 64'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_port.md
OUT_PORT -- requirements
Module: out_port

Interface
REQ-001 The block SHALL have parameters NUM_PORTS, default 3, number of logical ports addressed 0..2; DATA_W, default 32, payload width; address 2'b11 SHALL mean "no port".
REQ-002 gclock  input  1  single clock; all state changes on posedge gclock.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 c_addr  input  2  port selected by the core for writing.
REQ-005 c_write  input  1  core write strobe, sampled at posedge gclock, one word per high cycle.
REQ-006 c_data  input  DATA_W  word written by the core.
REQ-007 c_space  output  NUM_PORTS  per port, 1 = at least one free buffer entry.
REQ-008 c_drop  output  1  one-cycle pulse: a core write was discarded because the port was full.
REQ-009 o_addr  input  2  port selected by the ccm for sending to the interconnect.
REQ-010 valid_back  input  1  downstream flow control; 1 = downstream buffer full, word not accepted.
REQ-011 data_out  output  DATA_W+1  bit DATA_W = valid, bits DATA_W-1:0 = payload, feeding the downstream input port's data_in.

Function
REQ-012 Each port SHALL hold a 2-entry buffer with valid bit per entry, a write pointer and a read pointer (1 bit each, toggling).
REQ-013 Core write: at posedge, if c_write=1, c_addr!=3 and the entry at the port's write pointer is invalid, the entry SHALL store c_data, set valid and toggle the write pointer.
REQ-014 If c_write=1, c_addr!=3 and the port is full (both entries valid, judged on pre-edge state), the word SHALL be discarded and c_drop SHALL be 1 for the following cycle; c_addr=3 with c_write=1 SHALL be ignored without c_drop.
REQ-015 c_space[p] SHALL equal the inverse of the valid bit at port p's write pointer, combinationally from registered state.
REQ-016 o_addr SHALL be registered into o_addr_q each posedge; data_out SHALL be combinational from o_addr_q and state: all zeros when o_addr_q=3, else {valid, data} of the entry at that port's read pointer.
REQ-017 Send: at posedge, if o_addr_q!=3, data_out[DATA_W]=1 and valid_back=0, the word SHALL be consumed: entry valid cleared, read pointer toggled.
REQ-018 If valid_back=1, no state SHALL change on the send side; data_out SHALL hold the same word until accepted or o_addr_q changes.
REQ-019 Simultaneous core write and send on the same port SHALL both take effect in the same edge; a full port SHALL still drop the write even if a send empties an entry on that edge.
REQ-020 Changing o_addr between words SHALL not lose or duplicate data; only an accepted word (REQ-017) is removed.
REQ-021 Words SHALL leave each port in write order; ports are independent.
REQ-022 Minimum latency core write to data_out valid: 1 cycle (write edge, then visible if o_addr_q selects the port).

Reset
REQ-023 While reset=0: all valid bits, pointers and c_drop SHALL be 0, o_addr_q SHALL be 2'b11, data_out SHALL be all zeros, c_space SHALL be all ones; data storage need not be cleared.
REQ-024 Reset asserted mid-operation SHALL discard all buffered words immediately; first write after release SHALL land in entry 0 of its port.

Structure
REQ-025 NUM_PORTS, DATA_W, the no-port address constant 2'b11 and the data_out field positions SHALL live in shared package out_port_pkg, also used by the downstream input port.
REQ-026 The 2-entry per-port buffer SHALL be sub-module out_port_buf (push, pop, din, dout, dout_valid, not_full), instantiated NUM_PORTS times; out_port holds address decode, o_addr_q and c_drop.

Verification
REQ-027 Reset, write 0xA5A5_0001 to port 1, o_addr=1 -> next cycle data_out=1_A5A5_0001, valid_back=0 -> consumed, data_out valid bit drops to 0, c_space[1]=1.
REQ-028 Three writes to port 0 (0x1,0x2,0x3), o_addr=3 -> c_space[0]=0 after second, c_drop pulse after third; then sending returns 0x1, 0x2 only.
REQ-029 Port 2 holds 0x10, valid_back=1 for 5 cycles -> data_out stays 1_0000_0010, no pop; valid_back=0 -> popped once.
REQ-030 Port full with head 0x7, same edge: write 0x9 and send accepted -> 0x9 dropped (c_drop=1), remaining entry sent next.
REQ-031 Interleave o_addr 0,1,0,1 with two words each port -> each port outputs its words in order, none lost or duplicated.
REQ-032 Assert reset with all ports full -> data_out=0, c_space=3'b111 immediately; after release a write to port 0 then appears as first output.
